// File: rtl/uart_tx_queue.sv
// Byte queue that paces single-frame launches into the uart_top transmitter using tx_busy.
// Optional feature: define UART_TXQ_LEVEL_EN to drive the live queue count on level.
module uart_tx_queue #(
   parameter int DATABITS     = 8,
   parameter int DEPTH        = 16,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [DATABITS-1:0]      wr_data,
   input  logic                     flush,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   output logic                     launch_err,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     tx_en,
   output logic [DATABITS-1:0]      tx_data_in,
   input  logic                     tx_busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   logic [DATABITS-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_r;
   logic [PTR_W-1:0]    rd_ptr_r;
   logic [CNT_W-1:0]    count_r;
   state_t              state_r;
   state_t              state_s;
   logic [TMR_W-1:0]    timer_r;
   logic [TMR_W-1:0]    timer_s;
   logic                tx_en_r;
   logic                tx_en_s;
   logic                launch_err_r;
   logic                launch_err_s;
   logic                overflow_r;
   logic [DATABITS-1:0] tx_data_r;
   logic                push_s;
   logic                pop_s;
   logic                full_s;
   logic                empty_s;

   // Full is judged on the registered count, so a same-cycle pop never makes room for a push
   assign full_s  = (count_r == CNT_W'(DEPTH));
   assign empty_s = (count_r == {CNT_W{1'b0}});
   assign push_s  = wr_en && !full_s && !flush;

   // Queue storage write port
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointer and occupancy bookkeeping; flush wins over any same-cycle push
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky overflow flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_r <= 1'b0;
      end else if (wr_en && full_s) begin
         overflow_r <= 1'b1;
      end
   end

   // Launch sequencer next-state and next-output logic
   always_comb begin
      state_s      = state_r;
      timer_s      = timer_r;
      tx_en_s      = 1'b0;
      launch_err_s = launch_err_r;
      pop_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!empty_s && !tx_busy && !flush) begin
               pop_s   = 1'b1;
               tx_en_s = 1'b1;
               state_s = ST_LAUNCH;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            timer_s = {TMR_W{1'b0}};
            state_s = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_busy) begin
               state_s = ST_WAIT_DONE;
            end else if (timer_r == TMR_W'(BUSY_TIMEOUT - 1)) begin
               // Transmitter never acknowledged: the byte is dropped, not retried
               launch_err_s = 1'b1;
               state_s      = ST_IDLE;
            end else begin
               timer_s = timer_r + TMR_W'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_WAIT_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Launch sequencer state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         timer_r      <= {TMR_W{1'b0}};
         tx_en_r      <= 1'b0;
         launch_err_r <= 1'b0;
         tx_data_r    <= {DATABITS{1'b0}};
      end else begin
         state_r      <= state_s;
         timer_r      <= timer_s;
         tx_en_r      <= tx_en_s;
         launch_err_r <= launch_err_s;
         if (pop_s) begin
            tx_data_r <= mem_r[rd_ptr_r];
         end
      end
   end

   assign full       = full_s;
   assign empty      = empty_s;
   assign overflow   = overflow_r;
   assign launch_err = launch_err_r;
   assign tx_en      = tx_en_r;
   assign tx_data_in = tx_data_r;

`ifdef UART_TXQ_LEVEL_EN
   assign level = count_r;
`else
   assign level = {CNT_W{1'b0}};
`endif

endmodule
